// File: rtl/fetch_ctrl.sv
`default_nettype none
// =============================================================================
// fetch_ctrl : single-outstanding instruction fetch sequencer with a one-entry
//              decode buffer and redirect handling.  Revision 1.0
// =============================================================================
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              buf_valid_q, buf_valid_d;
  logic [31:0]       buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;

  logic              buf_drain;
  logic              buf_space;
  logic              req_fire;
  logic              buf_write;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_pc_aligned;
  logic              unused_redirect_lsb;

  assign buf_drain           = buf_valid_q & instr_ready_i;
  assign buf_space           = ~buf_valid_q | instr_ready_i;
  assign pc_plus4            = pc_q + ADDR_W'(4);
  assign redirect_pc_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // The request is withheld while decode holds a full buffer, so any granted
  // response always finds the buffer empty when it returns.
  assign mem_req_o  = (state_q == S_REQ) & buf_space;
  assign mem_addr_o = pc_q;
  assign req_fire   = mem_req_o & mem_gnt_i;
  assign buf_write  = (state_q == S_WAIT) & mem_rvalid_i & ~redirect_valid_i;

  assign instr_valid_o = buf_valid_q;
  assign instr_o       = buf_instr_q;
  assign instr_pc_o    = buf_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (buf_drain) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (buf_space) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_plus4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = buf_space ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (buf_write) begin
      buf_valid_d = 1'b1;
      buf_instr_d = mem_rdata_i;
      buf_pc_d    = req_pc_q;
    end

    // Redirect overrides everything except reset. A response landing in DROP
    // on the same cycle retires the killed request, so DROP need not persist.
    if (redirect_valid_i) begin
      pc_d        = redirect_pc_aligned;
      buf_valid_d = 1'b0;
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
        S_WAIT:  state_d = mem_rvalid_i ? S_REQ : S_DROP;
        S_DROP:  state_d = mem_rvalid_i ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC_ALIGNED;
      req_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// tb_fetch_ctrl: directed scenarios plus a randomized run checked against a
// PC-sequence model and an address-keyed instruction memory model.
module tb_fetch_ctrl;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int checks = 0;
  int errors = 0;

  // memory model controls: gnt_mode 0=never, 1=always, 2=random
  int          gnt_mode  = 1;
  int          lat_fixed = 0;
  bit          lat_rand  = 1'b0;
  bit          out_v      = 1'b0;
  bit          out_orphan = 1'b0;
  logic [31:0] out_addr   = '0;
  int          out_cnt    = 0;

  always #5 clk_i = ~clk_i;

  fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  function automatic bit delivered();
    return (instr_valid_o === 1'b1) && (instr_ready_i === 1'b1) &&
           (redirect_valid_i === 1'b0) && (rst_i === 1'b0);
  endfunction

  // Instruction memory: one response per grant, returned lat+1 cycles later.
  initial begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      #2;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (rst_i === 1'b1 && out_v) out_orphan = 1'b1;
      if (mem_req_o === 1'b1) begin
        checks++;
        if (out_v && !out_orphan) begin
          errors++;
          $display("FAIL one_outstanding: mem_req_o=1 while %h outstanding, want 0", out_addr);
        end
        checks++;
        if (mem_addr_o[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL addr_align: mem_addr_o=%h, want low bits 00", mem_addr_o);
        end
      end
      if (out_v) begin
        if (out_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word(out_addr);
          out_v        = 1'b0;
          out_orphan   = 1'b0;
        end else begin
          out_cnt--;
        end
      end
      if (mem_req_o === 1'b1 && !out_v && rst_i !== 1'b1) begin
        if (gnt_mode == 1) mem_gnt_i = 1'b1;
        else if (gnt_mode == 2) mem_gnt_i = ($urandom_range(0, 1) == 1);
        if (mem_gnt_i) begin
          out_v    = 1'b1;
          out_addr = mem_addr_o;
          out_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    gnt_mode = 1; lat_fixed = 0; lat_rand = 1'b0; instr_ready_i = 1'b1;
    do_reset();
    #3;
    checks++;
    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    checks++;
    if (mem_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", mem_addr_o, RESET_PC); end
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    checks++;
    if (instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_buf: instr=%h pc=%h want 0/0", instr_o, instr_pc_o);
    end
    @(negedge clk_i); #3;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== RESET_PC) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want 1/%h", mem_req_o, mem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    int n, last;
    exp = RESET_PC; n = 0; last = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk_i); #3;
      if (delivered()) begin
        checks++;
        if (instr_pc_o !== exp || instr_o !== mem_word(exp)) begin
          errors++; $display("FAIL stream_instr: pc=%h instr=%h want %h/%h", instr_pc_o, instr_o, exp, mem_word(exp));
        end
        if (n > 0) begin
          checks++;
          if (c - last != 2) begin errors++; $display("FAIL stream_rate: gap %0d cycles want 2", c - last); end
        end
        last = c; exp += 32'd4; n++;
      end
    end
    checks++;
    if (n < 5) begin errors++; $display("FAIL stream_timeout: got %0d instructions want 5", n); end
  endtask

  task automatic test_stall();
    bit found;
    gnt_mode = 1; lat_fixed = 0; instr_ready_i = 1'b0;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i); #3;
      if (instr_valid_o === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_first: no instruction, want pc %h", RESET_PC); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk_i); #3; end
      checks++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== mem_word(32'h0) || mem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b want 1/0/%h/0",
                 instr_valid_o, instr_pc_o, instr_o, mem_req_o, mem_word(32'h0));
      end
    end
    @(negedge clk_i);
    instr_ready_i = 1'b1;
    #3;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
      errors++; $display("FAIL stall_release_req: req=%b addr=%h want 1/4", mem_req_o, mem_addr_o);
    end
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i); #3;
      if (delivered()) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || instr_pc_o !== 32'h4 || instr_o !== mem_word(32'h4)) begin
      errors++; $display("FAIL stall_next: found=%b pc=%h instr=%h want pc 4 instr %h", found, instr_pc_o, instr_o, mem_word(32'h4));
    end
  endtask

  task automatic test_redirect_wait();
    bit found, req_seen;
    gnt_mode = 1; lat_fixed = 3; instr_ready_i = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i); #3;
      if (mem_req_o === 1'b1 && mem_addr_o === 32'h8) begin found = 1'b1; break; end
    end
    @(negedge clk_i);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h103;
    #3;
    checks++;
    if (!found || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL rdw_setup: found=%b req=%b want 1/0", found, mem_req_o);
    end
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #3;
    checks++;
    if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_flush: valid=%b want 0", instr_valid_o); end
    found = 1'b0; req_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(negedge clk_i); #3; end
      checks++;
      if (instr_valid_o === 1'b1 && instr_pc_o === 32'h8) begin
        errors++; $display("FAIL rdw_stale: pc %h delivered, want it discarded", instr_pc_o);
      end
      if (mem_req_o === 1'b1 && !req_seen) begin
        req_seen = 1'b1;
        checks++;
        if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL rdw_addr: addr=%h want 100", mem_addr_o); end
      end
      if (delivered()) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || instr_pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) begin
      errors++; $display("FAIL rdw_instr: found=%b pc=%h instr=%h want pc 100 instr %h", found, instr_pc_o, instr_o, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_req();
    bit found;
    int n;
    logic [31:0] exp;
    gnt_mode = 1; lat_fixed = 0; instr_ready_i = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i); #1;
      if (mem_req_o === 1'b1 && mem_addr_o === 32'h10) begin gnt_mode = 0; found = 1'b1; break; end
    end
    #2;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(negedge clk_i); #3; end
      checks++;
      if (!found || mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin
        errors++; $display("FAIL rdr_hold: found=%b req=%b addr=%h want 1/1/10", found, mem_req_o, mem_addr_o);
      end
    end
    @(negedge clk_i);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #3;
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
      errors++; $display("FAIL rdr_newaddr: req=%b addr=%h want 1/40", mem_req_o, mem_addr_o);
    end
    gnt_mode = 1;
    exp = 32'h40; n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk_i); #3;
      if (delivered()) begin
        checks++;
        if (instr_pc_o !== exp || instr_o !== mem_word(exp)) begin
          errors++; $display("FAIL rdr_instr: pc=%h instr=%h want %h/%h", instr_pc_o, instr_o, exp, mem_word(exp));
        end
        exp += 32'd4; n++;
      end
    end
    checks++;
    if (n < 2) begin errors++; $display("FAIL rdr_timeout: got %0d instructions want 2", n); end
  endtask

  task automatic test_simultaneous();
    bit found;
    gnt_mode = 1; lat_fixed = 0; instr_ready_i = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (instr_valid_o === 1'b1) begin
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80; found = 1'b1; break;
      end
    end
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    #3;
    checks++;
    if (!found || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL sim_flush: found=%b valid=%b want 1/0", found, instr_valid_o);
    end
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i); #3;
      if (delivered()) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || instr_pc_o !== 32'h80 || instr_o !== mem_word(32'h80)) begin
      errors++; $display("FAIL sim_next: found=%b pc=%h instr=%h want pc 80 instr %h", found, instr_pc_o, instr_o, mem_word(32'h80));
    end
    // reset and redirect together while a granted request is in flight
    lat_fixed = 3;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i); #3;
      if (mem_req_o === 1'b1) break;
    end
    @(negedge clk_i);
    rst_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
    @(negedge clk_i);
    rst_i = 1'b0; redirect_valid_i = 1'b0;
    #3;
    checks++;
    if (mem_addr_o !== RESET_PC || mem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL sim_rst_redirect: addr=%h req=%b valid=%b want %h/0/0", mem_addr_o, mem_req_o, instr_valid_o, RESET_PC);
    end
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i); #3;
      if (delivered()) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || instr_pc_o !== RESET_PC || instr_o !== mem_word(RESET_PC)) begin
      errors++; $display("FAIL sim_rst_next: found=%b pc=%h instr=%h want pc %h instr %h", found, instr_pc_o, instr_o, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    int n;
    gnt_mode = 1; lat_fixed = 0; instr_ready_i = 1'b1;
    @(negedge clk_i);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk_i);
    redirect_valid_i = 1'b0;
    exp = 32'hFFFF_FFFC; n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      if (c > 0) @(negedge clk_i);
      #3;
      if (delivered()) begin
        checks++;
        if (instr_pc_o !== exp || instr_o !== mem_word(exp)) begin
          errors++; $display("FAIL wrap_instr: pc=%h instr=%h want %h/%h", instr_pc_o, instr_o, exp, mem_word(exp));
        end
        exp += 32'd4; n++;
      end
    end
    checks++;
    if (n < 3) begin errors++; $display("FAIL wrap_timeout: got %0d instructions want 3", n); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_pc, prev_instr, prev_addr;
    bit prev_valid, prev_ready, prev_redir, prev_req, prev_gnt;
    int n;
    gnt_mode = 2; lat_rand = 1'b1; instr_ready_i = 1'b1;
    do_reset();
    exp_pc = RESET_PC; n = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0;
    prev_pc = '0; prev_instr = '0; prev_addr = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      instr_ready_i    = ($urandom_range(0, 3) != 0);
      redirect_valid_i = ($urandom_range(0, 24) == 0);
      redirect_pc_i    = $urandom;
      if ($urandom_range(0, 3) == 0) redirect_pc_i[31:4] = 28'hFFF_FFFF;
      #3;
      if (prev_valid && !prev_ready && !prev_redir) begin
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== prev_pc || instr_o !== prev_instr) begin
          errors++; $display("FAIL rand_hold: valid=%b pc=%h instr=%h want 1/%h/%h", instr_valid_o, instr_pc_o, instr_o, prev_pc, prev_instr);
        end
      end
      if (prev_req && !prev_gnt && !prev_redir && mem_req_o === 1'b1) begin
        checks++;
        if (mem_addr_o !== prev_addr) begin
          errors++; $display("FAIL rand_addr_stable: addr=%h want %h", mem_addr_o, prev_addr);
        end
      end
      if (redirect_valid_i) begin
        exp_pc = {redirect_pc_i[31:2], 2'b00};
      end else if (instr_valid_o === 1'b1 && instr_ready_i) begin
        checks++;
        if (instr_pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
          errors++; $display("FAIL rand_instr: pc=%h instr=%h want %h/%h", instr_pc_o, instr_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4; n++;
      end
      prev_valid = (instr_valid_o === 1'b1); prev_ready = instr_ready_i; prev_redir = redirect_valid_i;
      prev_req = (mem_req_o === 1'b1); prev_gnt = mem_gnt_i; prev_pc = instr_pc_o;
      prev_instr = instr_o; prev_addr = mem_addr_o;
    end
    @(negedge clk_i);
    redirect_valid_i = 1'b0; instr_ready_i = 1'b1;
    checks++;
    if (n < 50) begin errors++; $display("FAIL rand_progress: %0d instructions delivered, want at least 50", n); end
  endtask

  initial begin
    rst_i            = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    instr_ready_i    = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
